// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB slave register file with wait states, error detection and error counter
// Optional byte strobes: define APB_SLV_PSTRB_EN to add the PSTRB port.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [7:0]              err_count
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(NBYTES);
    localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NBYTES-1:0]     strb_q, strb_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [7:0]            errcnt_q, errcnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [NBYTES-1:0]     strb_in;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_write;
    logic [31:0]           idx_wide;
    logic [IDXW-1:0]       widx;
    logic                  xfer_err;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  set_ready;

`ifdef APB_SLV_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    // In IDLE the only decode that matters is the setup being latched this edge,
    // which lets WAIT_CYCLES=0 raise PREADY at the setup edge itself.
    assign cur_addr  = (state_q == S_IDLE) ? PADDR : addr_q;
    assign cur_write = (state_q == S_IDLE) ? PWRITE : write_q;
    assign idx_wide  = 32'(cur_addr >> LSB);
    assign widx      = idx_wide[IDXW-1:0];
    assign xfer_err  = (idx_wide >= 32'(DEPTH)) || ((cur_addr & ALIGN_MASK) != '0);
    assign rd_word   = mem_q[widx];

    always_comb begin
        merged = rd_word;
        for (int b = 0; b < NBYTES; b++) begin
            if (strb_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        errcnt_d  = errcnt_q;
        mem_d     = mem_q;
        set_ready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d   = S_ACCESS;
                    addr_d    = PADDR;
                    write_d   = PWRITE;
                    wdata_d   = PWDATA;
                    strb_d    = strb_in;
                    cnt_d     = WAIT_INIT;
                    set_ready = (WAIT_CYCLES == 0);
                end
            end
            default: begin
                if (!PSEL) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (!pready_q) begin
                    cnt_d     = cnt_q - 4'd1;
                    set_ready = (cnt_q == 4'd1);
                end else if (PENABLE) begin
                    if (write_q && !xfer_err) mem_d[widx] = merged;
                    if (pslverr_q && errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                    state_d   = S_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end
            end
        endcase

        if (set_ready) begin
            pready_d  = 1'b1;
            pslverr_d = xfer_err;
            prdata_d  = (cur_write || xfer_err) ? '0 : rd_word;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            errcnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            errcnt_q  <= errcnt_d;
            mem_q     <= mem_d;
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = pready_q;
    assign PSLVERR   = pslverr_q;
    assign err_count = errcnt_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed self-checking bench for apb_slave_regfile
module tb_apb_slave_regfile;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;
    logic [7:0]  errc0, errc1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(2)) dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
        .PSTRB(PSTRB),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .err_count(errc0)
    );

    apb_slave_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(16), .WAIT_CYCLES(0)) dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA),
`ifdef APB_SLV_PSTRB_EN
        .PSTRB(PSTRB),
`endif
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .err_count(errc1)
    );

    task automatic do_reset();
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
    endtask

    // One full transfer; sel picks which instance's handshake to follow.
    // Bus address/data are scrambled during ACCESS to prove they were latched.
    task automatic xfer(input int sel, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rdata, output logic serr, output int waits);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PADDR = addr ^ 8'h04; PWDATA = ~data; PSTRB = ~strb;
        waits = 0;
        while (!((sel == 1) ? pready1 : pready0) && waits < 40) begin
            @(posedge PCLK); #1;
            waits++;
        end
        n_cmp++;
        if (waits >= 40) begin
            n_err++;
            $display("FAIL xfer_timeout addr=%h: PREADY not seen within %0d cycles", addr, waits);
        end
        rdata = (sel == 1) ? prdata1 : prdata0;
        serr  = (sel == 1) ? pslverr1 : pslverr0;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        n_cmp++;
        if (((sel == 1) ? pready1 : pready0) !== 1'b0) begin
            n_err++;
            $display("FAIL pready_one_cycle addr=%h: got 1 after completion, want 0", addr);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic se; int w;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0;
        #1;
        n_cmp++;
        if ({prdata0, pready0, pslverr0, errc0, prdata1, pready1, pslverr1, errc1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h/%b/%b/%h %h/%b/%b/%h, want all 0",
                     prdata0, pready0, pslverr0, errc0, prdata1, pready1, pslverr1, errc1);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        xfer(0, 1'b0, 8'h3C, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h0 || se !== 1'b0 || w !== 2) begin
            n_err++;
            $display("FAIL reset_read_3c: got data=%h err=%b waits=%0d, want 00000000/0/2", rd, se, w);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic se; int w;
        xfer(0, 1'b1, 8'h08, 32'hDEADBEEF, 4'hF, rd, se, w);
        n_cmp++;
        if (rd !== 32'h0 || se !== 1'b0 || w !== 2) begin
            n_err++;
            $display("FAIL write_08_resp: got data=%h err=%b waits=%0d, want 00000000/0/2", rd, se, w);
        end
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'hDEADBEEF || se !== 1'b0) begin
            n_err++;
            $display("FAIL read_08: got %h err=%b, want deadbeef/0", rd, se);
        end
        xfer(1, 1'b1, 8'h0C, 32'h12345678, 4'hF, rd, se, w);
        n_cmp++;
        if (w !== 0 || se !== 1'b0) begin
            n_err++;
            $display("FAIL wait0_write_latency: got waits=%0d err=%b, want 0/0", w, se);
        end
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h12345678 || w !== 0) begin
            n_err++;
            $display("FAIL wait0_read_0c: got %h waits=%0d, want 12345678/0", rd, w);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic se; int w;
        do_reset();
        xfer(0, 1'b1, 8'h40, 32'h55555555, 4'hF, rd, se, w);
        n_cmp++;
        if (se !== 1'b1) begin
            n_err++;
            $display("FAIL err_range_write: got PSLVERR=%b, want 1", se);
        end
        xfer(0, 1'b1, 8'h09, 32'hFFFFFFFF, 4'hF, rd, se, w);
        n_cmp++;
        if (se !== 1'b1) begin
            n_err++;
            $display("FAIL err_misaligned_write: got PSLVERR=%b, want 1", se);
        end
        n_cmp++;
        if (errc0 !== 8'd2) begin
            n_err++;
            $display("FAIL err_count_2: got %0d, want 2", errc0);
        end
        xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h0 || se !== 1'b0) begin
            n_err++;
            $display("FAIL err_mem_00: got %h err=%b, want 00000000/0", rd, se);
        end
        xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h0 || se !== 1'b0) begin
            n_err++;
            $display("FAIL err_mem_08: got %h err=%b, want 00000000/0", rd, se);
        end
        xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h0 || se !== 1'b1 || errc0 !== 8'd3) begin
            n_err++;
            $display("FAIL err_read_40: got %h err=%b cnt=%0d, want 00000000/1/3", rd, se, errc0);
        end
    endtask

    task automatic test_pstrb();
        logic [31:0] rd; logic se; int w;
        logic [31:0] exp;
`ifdef APB_SLV_PSTRB_EN
        exp = 32'hAA22CC44;
`else
        exp = 32'h11223344;
`endif
        xfer(0, 1'b1, 8'h04, 32'hAABBCCDD, 4'hF, rd, se, w);
        xfer(0, 1'b1, 8'h04, 32'h11223344, 4'h5, rd, se, w);
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== exp) begin
            n_err++;
            $display("FAIL pstrb_merge: got %h, want %h", rd, exp);
        end
`ifdef APB_SLV_PSTRB_EN
        xfer(0, 1'b1, 8'h04, 32'hFFFFFFFF, 4'h0, rd, se, w);
        n_cmp++;
        if (se !== 1'b0) begin
            n_err++;
            $display("FAIL pstrb_zero_err: got PSLVERR=%b, want 0", se);
        end
        xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'hAA22CC44) begin
            n_err++;
            $display("FAIL pstrb_zero_data: got %h, want aa22cc44", rd);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd_a, rd_b, rd; logic se; int w; int c0;
        c0 = cyc;
        xfer(0, 1'b1, 8'h20, 32'hA5A5A5A5, 4'hF, rd, se, w);
        xfer(0, 1'b1, 8'h24, 32'h5A5A5A5A, 4'hF, rd, se, w);
        xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, rd_a, se, w);
        xfer(0, 1'b0, 8'h24, 32'h0, 4'h0, rd_b, se, w);
        n_cmp++;
        if (rd_a !== 32'hA5A5A5A5 || rd_b !== 32'h5A5A5A5A) begin
            n_err++;
            $display("FAIL b2b_data: got %h %h, want a5a5a5a5 5a5a5a5a", rd_a, rd_b);
        end
        n_cmp++;
        if (cyc - c0 !== 16) begin
            n_err++;
            $display("FAIL b2b_throughput: got %0d cycles for 4 transfers, want 16", cyc - c0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic se; int w; logic seen;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'hCAFEF00D; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | pready0;
            @(posedge PCLK); #1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_pready: got PREADY seen=%b, want 0", seen);
        end
        xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL abort_mem_10: got %h, want 00000000", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic se; int w;
        xfer(0, 1'b1, 8'h40, 32'h0, 4'hF, rd, se, w);
        xfer(0, 1'b1, 8'h18, 32'h0BADF00D, 4'hF, rd, se, w);
        xfer(0, 1'b0, 8'h18, 32'h0, 4'h0, rd, se, w);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h18; PWDATA = 32'h11111111; PSTRB = 4'hF;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2 PRESET = 1'b1;
        #1;
        n_cmp++;
        if (prdata0 !== 32'h0 || pready0 !== 1'b0 || pslverr0 !== 1'b0 || errc0 !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %h/%b/%b/%0d, want 0/0/0/0",
                     prdata0, pready0, pslverr0, errc0);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        xfer(0, 1'b0, 8'h18, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h0 || w !== 2) begin
            n_err++;
            $display("FAIL reset_mid_dropped: got %h waits=%0d, want 00000000/2", rd, w);
        end
        xfer(0, 1'b1, 8'h18, 32'h22222222, 4'hF, rd, se, w);
        xfer(0, 1'b0, 8'h18, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (rd !== 32'h22222222 || se !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_next: got %h err=%b, want 22222222/0", rd, se);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] rd; logic se; int w;
        do_reset();
        for (int i = 0; i < 200; i++) xfer(0, 1'b0, 8'h40, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (errc0 !== 8'd200) begin
            n_err++;
            $display("FAIL sat_200: got %0d, want 200", errc0);
        end
        for (int i = 0; i < 56; i++) xfer(0, 1'b0, 8'h41, 32'h0, 4'h0, rd, se, w);
        n_cmp++;
        if (errc0 !== 8'd255) begin
            n_err++;
            $display("FAIL sat_256: got %0d, want 255", errc0);
        end
        for (int i = 0; i < 3; i++) xfer(0, 1'b1, 8'h40, 32'h0, 4'hF, rd, se, w);
        n_cmp++;
        if (errc0 !== 8'd255) begin
            n_err++;
            $display("FAIL sat_hold: got %0d, want 255", errc0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_errors();
        test_pstrb();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
